// File: rtl/connect_game_ctrl_pkg.sv
// Shared types and helpers for the Connect-N controller.
// Holds the FSM state encoding, the default-board widths and the cell-index helper.
package connect_pkg;

  typedef enum logic [2:0] {
    READY,
    DROPPING,
    CHECK,
    RELEASE,
    REJECT_WAIT,
    OVER
  } state_t;

  localparam int DEF_ROWS    = 6;
  localparam int DEF_COLS    = 7;
  localparam int DEF_PLAYERS = 2;

  localparam int PW = $clog2(DEF_PLAYERS + 1);
  localparam int CW = $clog2(DEF_COLS);
  localparam int RW = $clog2(DEF_ROWS);

  // Flat cell number; multiply by the player-id width to get the bit offset.
  function automatic int cell_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/connect_game_ctrl_if.sv
// Bundle between the Connect-N controller and its environment.
// The master side drives switches and animation/checker results; the slave side is the controller.
interface connect_game_ctrl_if
  import connect_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int PLAYERS = DEF_PLAYERS
);

  localparam int PLAYER_W = $clog2(PLAYERS + 1);
  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);
  localparam int CNT_W    = $clog2(ROWS * COLS + 1);

  logic                          restart;
  logic [COLS-1:0]               col_sw;
  logic                          drop_done;
  logic                          win_detect;
  logic [ROWS*COLS*PLAYER_W-1:0] board_cells;
  logic [PLAYER_W-1:0]           player_turn;
  logic                          move_ready;
  logic                          move_req;
  logic [ROW_W-1:0]              move_row;
  logic [COL_W-1:0]              move_col;
  logic                          reject;
  logic                          waiting_for_switch;
  logic                          game_over;
  logic                          draw;
  logic [CNT_W-1:0]              move_count;

  modport master (
    output restart, col_sw, drop_done, win_detect,
    input  board_cells, player_turn, move_ready, move_req, move_row, move_col,
           reject, waiting_for_switch, game_over, draw, move_count
  );

  modport slave (
    input  restart, col_sw, drop_done, win_detect,
    output board_cells, player_turn, move_ready, move_req, move_row, move_col,
           reject, waiting_for_switch, game_over, draw, move_count
  );

endinterface

// File: rtl/column_height_tracker.sv
// Per-column token counters for the Connect-N board.
// Reports which columns are full and where the next token in the selected column lands.
module column_height_tracker #(
  parameter int ROWS  = 6,
  parameter int COLS  = 7,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [COL_W-1:0] inc_col,
  input  logic [COL_W-1:0] sel_col,
  output logic [COLS-1:0]  full,
  output logic [ROW_W-1:0] land_row
);

  localparam int HW = $clog2(ROWS + 1);

  logic [HW-1:0] height [COLS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) height[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < COLS; i++) height[i] <= '0;
    end else if (inc) begin
      height[inc_col] <= height[inc_col] + HW'(1);
    end
  end

  always_comb begin
    full = '0;
    for (int i = 0; i < COLS; i++) full[i] = (height[i] == HW'(ROWS));
  end

  // Row 0 is the top, so tokens stack upward from ROWS-1.
  assign land_row = ROW_W'(ROWS - 1 - int'(height[sel_col]));

endmodule

// File: rtl/connect_game_ctrl.sv
// Turn/board controller for Connect-N: accepts column requests, owns the board,
// and sequences drop, win/draw check and switch release.
module connect_game_ctrl
  import connect_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int PLAYERS = DEF_PLAYERS
) (
  input logic                clk,
  input logic                reset,
  connect_game_ctrl_if.slave bus
);

  localparam int PLAYER_W = $clog2(PLAYERS + 1);
  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);
  localparam int CNT_W    = $clog2(ROWS * COLS + 1);
  localparam int CELLS    = ROWS * COLS;

  state_t                    state;
  logic [CELLS*PLAYER_W-1:0] board;
  logic [PLAYER_W-1:0]       turn;
  logic [ROW_W-1:0]          row_q;
  logic [COL_W-1:0]          col_q;
  logic [CNT_W-1:0]          count;
  logic                      req_q, rej_q, ready_q, wait_q, over_q, draw_q;

  logic                      one_hot;
  logic [COL_W-1:0]          req_col;
  logic [COLS-1:0]           col_full;
  logic [ROW_W-1:0]          land_row;
  logic                      land_ok;

  // Switch bit COLS-1 is column 0.
  always_comb begin
    req_col = '0;
    for (int i = 0; i < COLS; i++)
      if (bus.col_sw[i]) req_col = COL_W'(COLS - 1 - i);
  end

  assign one_hot = (bus.col_sw != '0) && ((bus.col_sw & (bus.col_sw - COLS'(1))) == '0);
  assign land_ok = (state == DROPPING) && bus.drop_done && !bus.restart;

  column_height_tracker #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_heights (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.restart),
    .inc     (land_ok),
    .inc_col (col_q),
    .sel_col (req_col),
    .full    (col_full),
    .land_row(land_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= READY;   board  <= '0; turn   <= PLAYER_W'(1);
      row_q <= '0;      col_q  <= '0; count  <= '0;
      req_q <= 1'b0;    rej_q  <= 1'b0; ready_q <= 1'b1;
      wait_q <= 1'b0;   over_q <= 1'b0; draw_q  <= 1'b0;
    end else if (bus.restart) begin
      state <= READY;   board  <= '0; turn   <= PLAYER_W'(1);
      row_q <= '0;      col_q  <= '0; count  <= '0;
      req_q <= 1'b0;    rej_q  <= 1'b0; ready_q <= 1'b1;
      wait_q <= 1'b0;   over_q <= 1'b0; draw_q  <= 1'b0;
    end else begin
      req_q <= 1'b0;
      rej_q <= 1'b0;
      case (state)
        READY: begin
          if (one_hot) begin
            ready_q <= 1'b0;
            if (col_full[req_col]) begin
              rej_q  <= 1'b1;
              wait_q <= 1'b1;
              state  <= REJECT_WAIT;
            end else begin
              req_q <= 1'b1;
              row_q <= land_row;
              col_q <= req_col;
              state <= DROPPING;
            end
          end
        end
        DROPPING: begin
          if (bus.drop_done) begin
            board[cell_index(int'(row_q), int'(col_q), COLS)*PLAYER_W +: PLAYER_W] <= turn;
            count <= count + CNT_W'(1);
            state <= CHECK;
          end
        end
        // The board written on entry is what the external checker evaluates now.
        CHECK: begin
          if (bus.win_detect) begin
            over_q <= 1'b1;
            state  <= OVER;
          end else if (count == CNT_W'(CELLS)) begin
            over_q <= 1'b1;
            draw_q <= 1'b1;
            state  <= OVER;
          end else begin
            wait_q <= 1'b1;
            state  <= RELEASE;
          end
        end
        RELEASE, REJECT_WAIT: begin
          if (bus.col_sw == '0) begin
            if (state == RELEASE)
              turn <= (turn == PLAYER_W'(PLAYERS)) ? PLAYER_W'(1) : turn + PLAYER_W'(1);
            wait_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= READY;
          end
        end
        OVER: ;
        default: state <= READY;
      endcase
    end
  end

  assign bus.board_cells        = board;
  assign bus.player_turn        = turn;
  assign bus.move_ready         = ready_q;
  assign bus.move_req           = req_q;
  assign bus.move_row           = row_q;
  assign bus.move_col           = col_q;
  assign bus.reject             = rej_q;
  assign bus.waiting_for_switch = wait_q;
  assign bus.game_over          = over_q;
  assign bus.draw               = draw_q;
  assign bus.move_count         = count;

endmodule

// File: doc/connect_game_ctrl.md
Name: connect_game_ctrl

Overview:
Parametrised turn/board controller for Connect-N. Successor to the fixed 6x7, two-player game logic, generalised in rows, columns and player count. Adds per-column height tracking, full/multi-hot rejection, draw detection and a synchronous restart. Sits between the column switches and the drop-animation/win-checker blocks; owns the authoritative board state.

Parameters:
ROWS, 6, board rows; row 0 is the top row, ROWS-1 the bottom row.
COLS, 7, board columns; col_sw bit COLS-1 selects column 0.
PLAYERS, 2, number of players (2..7); player ids are 1..PLAYERS, and 0 means empty.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
restart  in  1  synchronous new-game pulse; acts in any state
col_sw  in  COLS  column switches, one-hot request
drop_done  in  1  animation has finished landing the token
win_detect  in  1  external checker result for the current board
board_cells  out  ROWS*COLS*PW  cell owner id, cell (r,c) at index (r*COLS+c)*PW; PW=$clog2(PLAYERS+1)
player_turn  out  PW  id of the current player, 1..PLAYERS
move_ready  out  1  controller is in READY
move_req  out  1  one-cycle pulse: accepted move
move_row  out  $clog2(ROWS)  landing row, held from move_req until the next accept
move_col  out  $clog2(COLS)  selected column, held likewise
reject  out  1  one-cycle pulse: request made on a full column
waiting_for_switch  out  1  controller is in RELEASE
game_over  out  1  game finished (win or draw)
draw  out  1  board is full with no winner
move_count  out  $clog2(ROWS*COLS+1)  number of tokens placed

Behaviour:
- Reset or restart: all cells 0, all heights 0, move_count 0, player_turn 1, state READY, move_ready 1. All pulse and flag outputs are 0; move_row and move_col are 0.
- The FSM has six states: READY, DROPPING, CHECK, RELEASE, REJECT_WAIT and OVER.
- READY, col_sw one-hot, column c not full (height[c] < ROWS):
  - Next cycle: move_req=1, move_col=c, move_row=ROWS-1-height[c].
  - State goes to DROPPING; move_ready=0.
- READY, col_sw one-hot, column c full: reject=1 for one cycle, then state goes to REJECT_WAIT. The turn does not change.
- READY, col_sw zero or multi-hot: ignored; state stays READY.
- DROPPING: the controller waits for drop_done. On drop_done:
  - Cell (move_row, move_col) is written with player_turn.
  - height[move_col] and move_count increment.
  - State goes to CHECK.
  - col_sw changes are ignored during DROPPING.
- CHECK lasts exactly one cycle. win_detect is sampled here; the checker sees the updated board in this cycle.
  - If win_detect=1: go to OVER, game_over=1, draw=0. player_turn holds the winner.
  - Else if move_count==ROWS*COLS: go to OVER, game_over=1, draw=1.
  - Else: go to RELEASE.
- RELEASE: waiting_for_switch=1. When col_sw==0:
  - player_turn advances (PLAYERS wraps to 1).
  - State goes to READY.
  - Minimum one cycle in RELEASE, even if col_sw is already 0.
- REJECT_WAIT: same as RELEASE (waiting_for_switch=1), but returns to READY without advancing the turn.
- OVER: all inputs are ignored except reset and restart. game_over and draw are held.
- drop_done outside DROPPING is ignored. win_detect outside CHECK is ignored.
- restart has priority over every state transition, including a simultaneous drop_done.
- Asynchronous reset mid-drop clears everything. A later drop_done is then ignored.
- move_count never exceeds ROWS*COLS. A full board always terminates in OVER before any further request.

Decomposition:
- Package connect_pkg holds:
  - the state enum (READY, DROPPING, CHECK, RELEASE, REJECT_WAIT, OVER);
  - the PW, CW and RW width localparams;
  - a cell-index function.
- One sub-module, column_height_tracker: it holds COLS height counters, provides full flags and the landing row, and supports increment and clear.

Test Plan:
- Use default params unless stated.
- First move, column 3: raise col_sw bit 3 (one-hot).
  - Response: one-cycle move_req with move_col=3, move_row=5.
  - Pulse drop_done: cell(5,3)=1, move_count=1, state CHECK then RELEASE.
  - Drop col_sw to 0: player_turn=2, move_ready=1.
- Column fill and reject: drop 6 tokens into column 0.
  - Rows land at 5,4,3,2,1,0.
  - Seventh request: reject pulse, no move_req, turn unchanged, height stays 6.
  - After release, player_turn is unchanged.
- Multi-hot input: col_sw=7'b0000011 in READY gives no move_req and no reject, and state stays READY.
  - Then col_sw=0, then a one-hot request: accepted.
- Win: assert win_detect during CHECK after move 7.
  - Response: game_over=1, draw=0, player_turn holds the winner.
  - Further col_sw and drop_done have no effect; restart clears the board and sets player_turn=1.
- Draw and parametrisation: ROWS=2, COLS=2, PLAYERS=3, win_detect=0.
  - Turns cycle 1,2,3,1.
  - After the 4th drop: game_over=1, draw=1, move_count=4.
- Reset mid-drop: assert reset during DROPPING.
  - All outputs return to reset values.
  - A drop_done after reset leaves the board empty.
